// File: rtl/sfx_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sfx_pkg : voice state encoding, volume->amplitude table, clamp   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package sfx_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } voice_state_t;

   localparam logic signed [15:0] AMP_0 = 16'sh0000;
   localparam logic signed [15:0] AMP_1 = 16'sh0800;
   localparam logic signed [15:0] AMP_2 = 16'sh1000;
   localparam logic signed [15:0] AMP_3 = 16'sh2000;
   localparam logic signed [15:0] AMP_4 = 16'sh3000;
   localparam logic signed [15:0] AMP_5 = 16'sh4000;

   function automatic logic signed [15:0] amp_of(input logic [3:0] vol);
      case (vol)
         4'd0:    amp_of = AMP_0;
         4'd1:    amp_of = AMP_1;
         4'd2:    amp_of = AMP_2;
         4'd3:    amp_of = AMP_3;
         4'd4:    amp_of = AMP_4;
         default: amp_of = AMP_5;
      endcase
   endfunction

   // Returns 2'b10 when x exceeds the w-bit signed max, 2'b01 below the min.
   function automatic logic [1:0] sat_dir(input logic signed [31:0] x, input int unsigned w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (x > hi)
         sat_dir = 2'b10;
      else if (x < lo)
         sat_dir = 2'b01;
      else
         sat_dir = 2'b00;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sfx_voice.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sfx_voice : one square-wave voice (FSM, divider, duration,       |
// | optional SFX_SWEEP_EN pitch sweep).  Rev 1.0                     |
// +------------------------------------------------------------------+
module sfx_voice
   import sfx_pkg::*;
#(
   parameter int DIV_W  = 22,
   parameter int DUR_W  = 32,
   parameter int AUD_W  = 16,
   parameter int RETRIG = 1
`ifdef SFX_SWEEP_EN
   ,
   parameter int SWEEP_PERIOD = 50000,
   parameter int SWEEP_STEP   = 64
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_trigger,
   input  logic [DIV_W-1:0]        i_div,
   input  logic [DUR_W-1:0]        i_dur,
   input  logic signed [15:0]      i_amp,
   output logic                    o_active,
   output logic signed [AUD_W-1:0] o_contrib
);

   voice_state_t     r_state;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_clk_cnt;
   logic [DUR_W-1:0] r_remain;
   logic             r_phase;

   logic             w_start;
   logic             w_load;
   logic [DIV_W-1:0] w_div_eff;

`ifdef SFX_SWEEP_EN
   logic [31:0]      r_sweep_cnt;
   logic [DIV_W:0]   w_div_step;
   assign w_div_step = {1'b0, r_div} + (DIV_W+1)'(SWEEP_STEP);
`endif

   assign w_start   = i_trigger && (i_dur != '0);
   assign w_load    = w_start && ((r_state == ST_IDLE) || (RETRIG != 0));
   assign w_div_eff = (r_div == '0) ? DIV_W'(1) : r_div;

   // A load also covers retrigger, so it takes priority over expiry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_div     <= '0;
         r_clk_cnt <= '0;
         r_remain  <= '0;
         r_phase   <= 1'b1;
`ifdef SFX_SWEEP_EN
         r_sweep_cnt <= '0;
`endif
      end else if (w_load) begin
         r_state   <= ST_PLAY;
         r_div     <= i_div;
         r_clk_cnt <= '0;
         r_remain  <= i_dur;
         r_phase   <= 1'b1;
`ifdef SFX_SWEEP_EN
         r_sweep_cnt <= '0;
`endif
      end else if (r_state == ST_PLAY) begin
         if (r_remain == DUR_W'(1)) begin
            r_state <= ST_IDLE;
         end else begin
            r_remain <= r_remain - DUR_W'(1);
            if (r_clk_cnt == w_div_eff) begin
               r_clk_cnt <= '0;
               r_phase   <= ~r_phase;
            end else begin
               r_clk_cnt <= r_clk_cnt + DIV_W'(1);
            end
`ifdef SFX_SWEEP_EN
            if (r_sweep_cnt == 32'(SWEEP_PERIOD - 1)) begin
               r_sweep_cnt <= '0;
               r_div       <= w_div_step[DIV_W] ? '1 : w_div_step[DIV_W-1:0];
            end else begin
               r_sweep_cnt <= r_sweep_cnt + 32'd1;
            end
`endif
         end
      end
   end

   assign o_active  = (r_state == ST_PLAY);
   assign o_contrib = !o_active ? '0 : (r_phase ? AUD_W'(i_amp) : -AUD_W'(i_amp));

endmodule
`default_nettype wire

// File: rtl/sfx_voice_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sfx_voice_engine : NUM_CH voices + ducking saturating mixer.     |
// | SFX_SWEEP_EN enables per-voice pitch sweep.  Rev 1.0             |
// +------------------------------------------------------------------+
module sfx_voice_engine
   import sfx_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DIV_W      = 22,
   parameter int DUR_W      = 32,
   parameter int AUD_W      = 16,
   parameter int DUCK_SHIFT = 1,
   parameter int RETRIG     = 1
`ifdef SFX_SWEEP_EN
   ,
   parameter int SWEEP_PERIOD = 50000,
   parameter int SWEEP_STEP   = 64
`endif
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         trigger,
   input  logic [NUM_CH*DIV_W-1:0]   note_div,
   input  logic [NUM_CH*DUR_W-1:0]   duration,
   input  logic [3:0]                vol_num,
   input  logic signed [AUD_W-1:0]   bgm_audio,
   output logic [NUM_CH-1:0]         voice_active,
   output logic signed [AUD_W-1:0]   audio
);

   localparam int SUM_W = AUD_W + $clog2(NUM_CH + 1);
   localparam logic signed [AUD_W-1:0] AUD_MAX = {1'b0, {(AUD_W-1){1'b1}}};
   localparam logic signed [AUD_W-1:0] AUD_MIN = {1'b1, {(AUD_W-1){1'b0}}};

   logic signed [15:0]      w_amp;
   logic signed [AUD_W-1:0] w_contrib [NUM_CH];
   logic signed [SUM_W-1:0] w_sum;
   logic [1:0]              w_sat;

   assign w_amp = amp_of(vol_num);

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
         sfx_voice #(
            .DIV_W  (DIV_W),
            .DUR_W  (DUR_W),
            .AUD_W  (AUD_W),
            .RETRIG (RETRIG)
`ifdef SFX_SWEEP_EN
            ,
            .SWEEP_PERIOD (SWEEP_PERIOD),
            .SWEEP_STEP   (SWEEP_STEP)
`endif
         ) u_voice (
            .clk       (clk),
            .rst       (rst),
            .i_trigger (trigger[g]),
            .i_div     (note_div[g*DIV_W +: DIV_W]),
            .i_dur     (duration[g*DUR_W +: DUR_W]),
            .i_amp     (w_amp),
            .o_active  (voice_active[g]),
            .o_contrib (w_contrib[g])
         );
      end
   endgenerate

   always_comb begin
      w_sum = SUM_W'(bgm_audio);
      if (|voice_active)
         w_sum = w_sum >>> DUCK_SHIFT;
      for (int i = 0; i < NUM_CH; i++)
         w_sum = w_sum + SUM_W'(w_contrib[i]);
   end

   assign w_sat = sat_dir(32'(w_sum), AUD_W);

   always_ff @(posedge clk) begin
      if (rst) begin
         audio <= '0;
      end else begin
         case (w_sat)
            2'b10:   audio <= AUD_MAX;
            2'b01:   audio <= AUD_MIN;
            default: audio <= w_sum[AUD_W-1:0];
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sfx_voice_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sfx_voice_engine : scoreboard bench with behavioural model.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_sfx_voice_engine;

   localparam int NUM_CH     = 4;
   localparam int DIV_W      = 22;
   localparam int DUR_W      = 32;
   localparam int AUD_W      = 16;
   localparam int DUCK_SHIFT = 1;
   localparam int RETRIG     = 1;
   localparam int S_MAX      = (1 << (AUD_W - 1)) - 1;
   localparam int S_MIN      = -(1 << (AUD_W - 1));

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       trigger;
   logic [NUM_CH*DIV_W-1:0] note_div;
   logic [NUM_CH*DUR_W-1:0] duration;
   logic [3:0]              vol_num;
   logic signed [AUD_W-1:0] bgm_audio;
   logic [NUM_CH-1:0]       voice_active;
   logic signed [AUD_W-1:0] audio;

   always #5 clk = ~clk;

   sfx_voice_engine #(
      .NUM_CH     (NUM_CH),
      .DIV_W      (DIV_W),
      .DUR_W      (DUR_W),
      .AUD_W      (AUD_W),
      .DUCK_SHIFT (DUCK_SHIFT),
      .RETRIG     (RETRIG)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .trigger      (trigger),
      .note_div     (note_div),
      .duration     (duration),
      .vol_num      (vol_num),
      .bgm_audio    (bgm_audio),
      .voice_active (voice_active),
      .audio        (audio)
   );

   // Model: remaining play cycles, cycles played so far, latched divider.
   int m_rem [NUM_CH];
   int m_age [NUM_CH];
   int m_div [NUM_CH];

   logic [AUD_W-1:0]  q_audio [$];
   logic [NUM_CH-1:0] q_act   [$];

   int checks = 0;
   int passes = 0;

   function automatic int amp_model(input int v);
      if (v == 0)      return 0;
      else if (v == 1) return 2048;
      else if (v == 2) return 4096;
      else if (v == 3) return 8192;
      else if (v == 4) return 12288;
      else             return 16384;
   endfunction

   // Predicts the outputs after the next clock edge from the current inputs.
   function automatic void model_edge();
      int sum, amp, de, d;
      bit any;
      logic [NUM_CH-1:0] act;
      any = 1'b0;
      for (int i = 0; i < NUM_CH; i++)
         if (m_rem[i] > 0) any = 1'b1;
      amp = amp_model(int'(vol_num));
      sum = int'(bgm_audio);
      if (any) sum = sum >>> DUCK_SHIFT;
      for (int i = 0; i < NUM_CH; i++) begin
         if (m_rem[i] > 0) begin
            de = (m_div[i] == 0) ? 1 : m_div[i];
            sum += (((m_age[i] / (de + 1)) % 2) == 0) ? amp : -amp;
         end
      end
      if (sum > S_MAX) sum = S_MAX;
      if (sum < S_MIN) sum = S_MIN;
      if (rst) begin
         sum = 0;
         for (int i = 0; i < NUM_CH; i++) m_rem[i] = 0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            d = int'(duration[i*DUR_W +: DUR_W]);
            if (trigger[i] && d != 0 && (m_rem[i] == 0 || RETRIG != 0)) begin
               m_rem[i] = d;
               m_age[i] = 0;
               m_div[i] = int'(note_div[i*DIV_W +: DIV_W]);
            end else if (m_rem[i] > 0) begin
               m_rem[i] = m_rem[i] - 1;
               m_age[i] = m_age[i] + 1;
            end
         end
      end
      for (int i = 0; i < NUM_CH; i++) act[i] = (m_rem[i] > 0);
      q_audio.push_back(AUD_W'(sum));
      q_act.push_back(act);
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic set_voice(input int i, input int dv, input int du);
      note_div[i*DIV_W +: DIV_W] = DIV_W'(dv);
      duration[i*DUR_W +: DUR_W] = DUR_W'(du);
   endtask

   // Monitor: every edge with a pending expectation is compared.
   initial begin
      logic [AUD_W-1:0]  exp_a;
      logic [NUM_CH-1:0] exp_v;
      forever begin
         @(posedge clk);
         #1;
         if (q_audio.size() > 0) begin
            exp_a = q_audio.pop_front();
            exp_v = q_act.pop_front();
            checks++;
            if (audio === exp_a) passes++;
            else $display("FAIL audio: got %h expected %h at %0t", audio, exp_a, $time);
            checks++;
            if (voice_active === exp_v) passes++;
            else $display("FAIL voice_active: got %b expected %b at %0t", voice_active, exp_v, $time);
         end
      end
   end

   initial begin
      for (int i = 0; i < NUM_CH; i++) begin
         m_rem[i] = 0;
         m_age[i] = 0;
         m_div[i] = 0;
      end
      rst = 1'b1; trigger = '0; note_div = '0; duration = '0;
      vol_num = 4'd0; bgm_audio = 16'sh1234;
      @(posedge clk);
      #2;
      repeat (3) tick();
      rst = 1'b0;
      repeat (3) tick();

      // Single voice, ducked bgm
      vol_num = 4'd5; bgm_audio = 16'sh0100;
      set_voice(0, 3, 16); trigger = 4'b0001; tick(); trigger = '0;
      repeat (20) tick();

      // All voices in phase against loud bgm: clamps both ways
      bgm_audio = 16'sh7000;
      for (int i = 0; i < NUM_CH; i++) set_voice(i, 2, 12);
      trigger = 4'b1111; tick(); trigger = '0;
      repeat (14) tick();

      // Retrigger on the final active cycle
      bgm_audio = 16'sh0000;
      set_voice(1, 1, 16); trigger = 4'b0010; tick(); trigger = '0;
      repeat (15) tick();
      set_voice(1, 2, 10); trigger = 4'b0010; tick(); trigger = '0;
      repeat (12) tick();

      // Zero duration, zero divider, muted volume
      set_voice(2, 3, 0); trigger = 4'b0100; tick(); trigger = '0;
      repeat (3) tick();
      set_voice(2, 0, 9); trigger = 4'b0100; tick(); trigger = '0;
      repeat (10) tick();
      vol_num = 4'd0; bgm_audio = 16'sh0400;
      set_voice(3, 1, 6); trigger = 4'b1000; tick(); trigger = '0;
      repeat (8) tick();

      // Reset in the middle of play
      vol_num = 4'd3;
      set_voice(0, 2, 20); trigger = 4'b0001; tick(); trigger = '0;
      repeat (5) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (4) tick();

      // Randomised traffic
      for (int n = 0; n < 600; n++) begin
         if (n % 25 == 0) vol_num = 4'($urandom_range(0, 15));
         bgm_audio = AUD_W'($urandom);
         for (int i = 0; i < NUM_CH; i++) begin
            trigger[i] = ($urandom_range(0, 9) == 0);
            if (trigger[i]) set_voice(i, $urandom_range(0, 6), $urandom_range(0, 24));
         end
         rst = ($urandom_range(0, 149) == 0);
         tick();
      end
      trigger = '0; rst = 1'b0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
